// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the multichannel FIR.
// Used by the top, the MAC datapath and the bench.
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_MAC,
    S_WRITE
  } state_t;

  function automatic int acc_w(input int dw, input int taps);
    return 2 * dw + $clog2(taps);
  endfunction

  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/fir_mc_if.sv
// Sample source and result sink handshake of the FIR.
// master is the filter side, slave the source/sink side.
interface fir_mc_if #(
  parameter int DW = 16,
  parameter int CW = 1
);
  logic          read_req;
  logic          read_ready;
  logic [DW-1:0] read_data;
  logic          write_req;
  logic [DW-1:0] write_data;
  logic [CW-1:0] write_ch;

  modport master (
    output read_req, write_req, write_data, write_ch,
    input  read_ready, read_data
  );

  modport slave (
    input  read_req, write_req, write_data, write_ch,
    output read_ready, read_data
  );
endinterface

// File: rtl/fir_mac.sv
// Serial MAC: one signed product per cycle, Q1.(DW-1)
// rescale and saturation of the running sum.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DW   = 16,
  parameter int TAPS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic        [DW-1:0] res
);
  localparam int AW = acc_w(DW, TAPS);
  localparam logic signed [AW-1:0] SMAX = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] SMIN = AW'(sat_min(DW));

  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_nx;
  logic signed [AW-1:0]   sh;
  logic signed [2*DW-1:0] prod;

  assign prod   = a * b;
  assign acc_nx = acc + AW'(prod);
  assign sh     = acc_nx >>> (DW - 1);

  // res reflects the sum including this cycle's product
  always_comb begin
    res = sh[DW-1:0];
    unique case (1'b1)
      (sh > SMAX): res = {1'b0, {(DW-1){1'b1}}};
      (sh < SMIN): res = {1'b1, {(DW-1){1'b0}}};
      default:     res = sh[DW-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nx;
    end
  end

endmodule

// File: rtl/fir_mc_top.sv
// Time-interleaved multichannel FIR: request a sample,
// run TAPS MAC cycles, emit one result, next channel.
module fir_mc_top
  import fir_pkg::*;
#(
  parameter int DW   = 16,
  parameter int TAPS = 8,
  parameter int CH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fir_en,
  input  logic               read_quit,
  input  logic               flush,
  input  logic [TAPS*DW-1:0] coef,
  output logic               busy,
  fir_mc_if.master           bus
);
  localparam int TW = $clog2(TAPS);
  localparam int CW = ch_w(CH);

  state_t st, st_nx;

  logic [TW-1:0]        tap;
  logic [CW-1:0]        chp;
  logic signed [DW-1:0] dl [CH][TAPS];
  logic signed [DW-1:0] cr [TAPS];
  logic [DW-1:0]        wd;
  logic [DW-1:0]        mac_res;
  logic                 abort;
  logic                 accept;
  logic                 last;

  assign abort  = ~fir_en | read_quit;
  assign accept = (st == S_READ) & bus.read_ready & ~abort & ~flush;
  assign last   = (st == S_MAC) && (tap == TW'(TAPS - 1));

  assign bus.read_req   = (st == S_READ);
  assign bus.write_req  = (st == S_WRITE);
  assign bus.write_data = wd;
  assign bus.write_ch   = chp;
  assign busy           = (st != S_IDLE);

  always_comb begin
    st_nx = st;
    if (flush || abort) begin
      st_nx = S_IDLE;
    end else begin
      unique case (st)
        S_IDLE:  st_nx = S_READ;
        S_READ:  st_nx = bus.read_ready ? S_MAC : S_READ;
        S_MAC:   st_nx = last ? S_WRITE : S_MAC;
        S_WRITE: st_nx = S_READ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= S_IDLE;
      tap <= '0;
      chp <= '0;
      wd  <= '0;
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < TAPS; k++)
          dl[c][k] <= '0;
      for (int k = 0; k < TAPS; k++)
        cr[k] <= '0;
    end else begin
      st  <= st_nx;
      tap <= (st == S_MAC && st_nx == S_MAC) ? tap + 1'b1 : '0;
      if (last && !abort && !flush)
        wd <= mac_res;
      if (flush) begin
        chp <= '0;
        for (int c = 0; c < CH; c++)
          for (int k = 0; k < TAPS; k++)
            dl[c][k] <= '0;
      end else begin
        if (accept) begin
          for (int k = TAPS - 1; k > 0; k--)
            dl[chp][k] <= dl[chp][k-1];
          dl[chp][0] <= $signed(bus.read_data);
          for (int k = 0; k < TAPS; k++)
            cr[k] <= $signed(coef[k*DW +: DW]);
        end
        // the pulse already went out, so the channel moves on
        if (st == S_WRITE)
          chp <= (chp == CW'(CH - 1)) ? '0 : chp + 1'b1;
      end
    end
  end

  fir_mac #(
    .DW   (DW),
    .TAPS (TAPS)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (accept | abort | flush),
    .en    (st == S_MAC),
    .a     (cr[tap]),
    .b     (dl[chp][tap]),
    .res   (mac_res)
  );

endmodule

// File: tb/tb_fir_mc_top.sv
// Directed bench for fir_mc_top with an arithmetic FIR model
// and a per-cycle scoreboard on the write strobe.
module tb_fir_mc_top;
  localparam int DW   = 16;
  localparam int TAPS = 8;
  localparam int CH   = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               fir_en = 1'b0;
  logic               read_quit = 1'b0;
  logic               flush = 1'b0;
  logic [TAPS*DW-1:0] coef = '0;
  logic               busy;

  fir_mc_if #(.DW(DW), .CW(1)) bus ();

  fir_mc_top #(
    .DW   (DW),
    .TAPS (TAPS),
    .CH   (CH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fir_en    (fir_en),
    .read_quit (read_quit),
    .flush     (flush),
    .coef      (coef),
    .busy      (busy),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    int          ch;
  } exp_t;

  exp_t               q[$];
  logic signed [15:0] hist [CH][TAPS];
  int                 chp = 0;
  logic [15:0]        last_out [CH];
  int                 last_ch = -1;

  task automatic check(input string nm, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [15:0] model(input int ch, input logic [TAPS*DW-1:0] cf);
    longint s = 0;
    for (int k = 0; k < TAPS; k++)
      s += longint'($signed(cf[k*DW +: DW])) * longint'(hist[ch][k]);
    s = s >>> 15;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic clear_model();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++)
        hist[c][k] = '0;
    chp = 0;
  endtask

  task automatic push_hist(input int ch, input logic [15:0] x);
    for (int k = TAPS - 1; k > 0; k--)
      hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = x;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.read_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = bus.read_req;
    if (!ok) check("read_req_timeout", 0, 1);
  endtask

  task automatic send(input logic [15:0] x);
    bit ok;
    wait_req(ok);
    if (ok) begin
      bus.read_ready = 1'b1;
      bus.read_data  = x;
      push_hist(chp, x);
      q.push_back('{cyc + TAPS + 1, model(chp, coef), chp});
      chp = (chp + 1) % CH;
      @(negedge clk);
      bus.read_ready = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clear_model();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.write_req) begin
      if (q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = q.pop_front();
        check("write_cycle", cyc, e.cyc);
        check("write_data", bus.write_data, e.d);
        check("write_ch", bus.write_ch, e.ch);
        last_out[e.ch] = bus.write_data;
        last_ch = e.ch;
      end
    end else if (q.size() > 0 && cyc > q[0].cyc) begin
      check("missing_write", cyc, q[0].cyc);
      void'(q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.read_ready = 1'b0;
    bus.read_data  = '0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_read_req", bus.read_req, 0);
    check("rst_write_req", bus.write_req, 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_write_ch", bus.write_ch, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // single tap, impulse-style latency and rounding
    coef[15:0] = 16'h7fff;
    fir_en = 1'b1;
    send(16'h1234);
    send(16'h0000);
    drain();
    check("lit_1233", last_out[0], 16'h1233);

    // saturation both ways
    pulse_flush();
    for (int k = 0; k < TAPS; k++) coef[k*DW +: DW] = 16'h7fff;
    for (int i = 0; i < 8; i++) begin
      send(16'h7fff);
      send(16'h8000);
    end
    drain();
    check("lit_sat_pos", last_out[0], 16'h7fff);
    check("lit_sat_neg", last_out[1], 16'h8000);

    // history then flush then impulse on ch0
    pulse_flush();
    for (int i = 0; i < 5; i++) send(16'h7fff);
    drain();
    pulse_flush();
    send(16'h4000);
    send(16'h0000);
    drain();
    check("lit_flush_imp", last_out[0], 16'h3fff);
    check("lit_ch1_zero", last_out[1], 16'h0000);
    for (int i = 0; i < 7; i++) begin
      send(16'h0000);
      send(16'h0000);
    end
    drain();
    check("lit_imp_8th", last_out[0], 16'h3fff);
    send(16'h0000);
    send(16'h0000);
    drain();
    check("lit_imp_9th", last_out[0], 16'h0000);

    // abort in the 4th MAC cycle
    pulse_flush();
    wait_req(ok);
    bus.read_ready = 1'b1;
    bus.read_data  = 16'h2000;
    push_hist(0, 16'h2000);
    @(negedge clk);
    bus.read_ready = 1'b0;
    repeat (3) @(negedge clk);
    read_quit = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_read_req", bus.read_req, 0);
    repeat (2) @(negedge clk);
    read_quit = 1'b0;
    // abort coincident with accept discards the sample
    wait_req(ok);
    bus.read_ready = 1'b1;
    bus.read_data  = 16'h4000;
    read_quit = 1'b1;
    @(negedge clk);
    bus.read_ready = 1'b0;
    read_quit = 1'b0;
    check("coinc_busy", busy, 0);
    send(16'h0000);
    drain();
    check("lit_resume", last_out[0], 16'h1fff);
    check("lit_resume_ch", last_ch, 0);

    // reset in the middle of MAC
    send(16'h4000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    check("mid_rst_read_req", bus.read_req, 0);
    check("mid_rst_write_req", bus.write_req, 0);
    check("mid_rst_write_data", bus.write_data, 0);
    check("mid_rst_write_ch", bus.write_ch, 0);
    check("mid_rst_busy", busy, 0);
    clear_model();
    reset = 1'b0;
    send(16'h4000);
    send(16'h0000);
    drain();
    check("lit_post_rst", last_out[0], 16'h3fff);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mc_top.md
FIR_MC_TOP -- requirements
Module: fir_mc_top

Interface
REQ-001 SHALL have parameter DW, default 16, meaning sample and coefficient width (signed two's complement).
REQ-002 SHALL have parameter TAPS, default 8, meaning filter length (2..64).
REQ-003 SHALL have parameter CH, default 2, meaning number of time-interleaved channels (1..8).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fir_en  input  1  run enable.
REQ-007 SHALL have port read_quit  input  1  abort/halt request.
REQ-008 SHALL have port flush  input  1  zero all delay lines.
REQ-009 SHALL have port read_req  output  1  sample request.
REQ-010 SHALL have port read_ready  input  1  source has sample on read_data.
REQ-011 SHALL have port read_data  input  DW  input sample.
REQ-012 SHALL have port write_req  output  1  one-cycle output strobe.
REQ-013 SHALL have port write_data  output  DW  filtered sample.
REQ-014 SHALL have port write_ch  output  clog2(CH) (min 1)  channel of write_data.
REQ-015 SHALL have port coef  input  TAPS*DW  flattened coefficients, tap k at bits [k*DW +: DW].
REQ-016 SHALL have port busy  output  1  high in any state but IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, READ, MAC, WRITE.
REQ-018 SHALL move IDLE->READ when fir_en=1 and read_quit=0.
REQ-019 SHALL hold read_req=1 throughout READ; a cycle with read_ready=1 is the accept: read_data shifted into the delay line of the current channel, read_req low next cycle, go MAC.
REQ-020 SHALL latch coef into an internal register on accept; coef changes during MAC do not affect the current output.
REQ-021 SHALL perform one signed DW x DW multiply-accumulate per MAC cycle, exactly TAPS cycles, tap 0 on newest sample.
REQ-022 SHALL size the accumulator 2*DW+clog2(TAPS) bits, no internal overflow.
REQ-023 SHALL form the result as accumulator arithmetic-shifted right DW-1 (Q1.(DW-1)), truncating toward minus infinity, then saturate to DW bits (max 2^(DW-1)-1, min -2^(DW-1)).
REQ-024 SHALL in WRITE assert write_req for exactly one cycle with write_data/write_ch valid that cycle, then advance the channel pointer (wrap CH-1->0) and go READ.
REQ-025 SHALL give latency accept cycle t -> write_req high in cycle t+TAPS+1.
REQ-026 SHALL, when fir_en=0 or read_quit=1 in any state, go IDLE next cycle, drop partial result, emit no write_req, deassert read_req; delay lines and channel pointer kept.
REQ-027 SHALL give abort priority over a coincident accept (sample discarded, delay line unchanged).
REQ-028 SHALL, on flush=1, zero all delay lines and channel pointer next cycle and abort as REQ-026; flush has priority over abort and accept.
REQ-029 SHALL keep write_data stable between write_req pulses.

Reset
REQ-030 SHALL on reset=1 set state IDLE, read_req=0, write_req=0, write_data=0, write_ch=0, busy=0, channel pointer 0, all delay lines 0, accumulator 0; reset has priority over all inputs.

Structure
REQ-031 SHALL place the state encoding, accumulator-width function and saturation limits in shared package fir_pkg.
REQ-032 SHALL instantiate one sub-module fir_mac (multiply, accumulate, shift, saturate), the FSM and delay-line RAM staying in fir_mc_top.

Verification
REQ-033 SHALL cover: TAPS=8, CH=1, coef[0]=0x7FFF, others 0, input 0x1234 -> write_data 0x1233, write_req 9 cycles after accept.
REQ-034 SHALL cover: all coef 0x7FFF, eight inputs 0x7FFF -> 8th output 0x7FFF (saturated); eight inputs 0x8000 -> 8th output 0x8000.
REQ-035 SHALL cover: CH=2, ch0 impulse 0x4000 then zeros, ch1 all 0x0000, coef[k]=0x7FFF -> ch1 outputs 0x0000, ch0 outputs 0x3FFF for 8 ch0 samples then 0x0000; write_ch alternates 0,1.
REQ-036 SHALL cover: read_quit=1 during 4th MAC cycle -> no write_req, IDLE next cycle, resume after release with same channel.
REQ-037 SHALL cover: flush=1 after 5 samples, then impulse 0x4000 -> outputs show no prior history; reset mid-MAC -> all outputs 0 next cycle.
